alu_op_sequencer: RTL and testbench

//  Front-end controller for the shared 32-bit MIPSALU. Accepts one op per request over a valid/ready handshake.

---
 rtl/alu_op_sequencer_pkg.sv | 41 ++++
 rtl/alu_op_sequencer_mul_shift_reg.sv | 77 +++++++
 rtl/alu_op_sequencer.sv | 152 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer_pkg
// Shared definitions for the ALU op sequencer: datapath width, multiply
// iteration count, ALU control codes, the MULT request code and the FSM
// state encoding. Also provides a helper that classifies request codes
// that map directly onto a single ALU operation.
// -----------------------------------------------------------------------------
package alu_op_sequencer_pkg;

    // Datapath width is tied to the shared ALU and is not a tunable.
    localparam int WIDTH    = 32;
    localparam int MUL_ITER = WIDTH;
    localparam int CNT_W    = $clog2(MUL_ITER);

    // ALU control codes as understood by the MIPSALU.
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Request code for the multi-cycle unsigned multiply.
    localparam logic [3:0] OP_MULT = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // True for request codes that are forwarded to the ALU unchanged.
    function automatic logic is_single_op(input logic [3:0] op);
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: is_single_op = 1'b1;
            default:                                            is_single_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_sequencer_mul_shift_reg.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer_mul_shift_reg
// HI/LO/M registers of the shift-add multiplier. Each step adds the current
// addend (M when LO[0] is set, otherwise 0) to HI through the external ALU,
// then shifts {carry, sum, LO} right by one bit.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   load              start a multiply: HI=0, LO=multiplier, M=multiplicand
//   step              perform one shift-add iteration using alu_result
//   multiplicand      operand captured into M on load
//   multiplier        operand captured into LO on load
//   alu_result        HI + addend as computed by the ALU this cycle
//   hi_next, lo_next  values HI/LO take on the coming edge
//   addend_next       ALU b operand for the iteration after the coming edge
// -----------------------------------------------------------------------------
module alu_op_sequencer_mul_shift_reg
    import alu_op_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next,
    output logic [WIDTH-1:0] addend_next
);

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] m_next;
    logic [WIDTH-1:0] addend;
    logic             carry;

    assign addend = lo[0] ? m : '0;

    // Carry out of HI + addend, rebuilt from the operand and sum MSBs since
    // the ALU exposes no carry output.
    assign carry = (hi[WIDTH-1] & addend[WIDTH-1])
                 | ((hi[WIDTH-1] | addend[WIDTH-1]) & ~alu_result[WIDTH-1]);

    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    always_comb begin
        hi_next = hi;
        lo_next = lo;
        m_next  = m;
        if (load) begin
            hi_next = '0;
            lo_next = multiplier;
            m_next  = multiplicand;
        end else if (step) begin
            {hi_next, lo_next} = {carry, alu_result, lo[WIDTH-1:1]};
        end
    end

    assign addend_next = lo_next[0] ? m_next : '0;

    // NOTE: state registers use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
            m  <= '0;
        end else begin
            hi <= hi_next;
            lo <= lo_next;
            m  <= m_next;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
// Front-end controller for the shared 32-bit MIPSALU. Accepts one request at
// a time over valid/ready, issues single-cycle ops to the ALU once, and runs
// an unsigned 32x32->64 multiply as 32 shift-add iterations on the ALU adder.
// It is the sole driver of the ALU inputs; the ALU itself lives in the parent.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_op, req_a, req_b  operation code and operands
//   rsp_valid/rsp_ready   response handshake (response held until taken)
//   rsp_lo, rsp_hi        result low/high words (hi is 0 except for MULT)
//   rsp_zero              full 64-bit response is zero
//   rsp_err               request code was not supported
//   alu_ctrl, alu_a/b     ALU control and operands (all zero when not in use)
//   alu_result            combinational ALU result, sampled the same cycle
// -----------------------------------------------------------------------------
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_lo,
    output logic [WIDTH-1:0] rsp_hi,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITER - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             mul_load;
    logic             mul_step;
    logic [WIDTH-1:0] hi_next;
    logic [WIDTH-1:0] lo_next;
    logic [WIDTH-1:0] addend_next;

    assign req_ready = (state == ST_IDLE);
    assign mul_load  = (state == ST_IDLE) && req_valid && (req_op == OP_MULT);
    assign mul_step  = (state == ST_MUL);

    alu_op_sequencer_mul_shift_reg u_mul (
        .clk          (clk),
        .reset        (reset),
        .load         (mul_load),
        .step         (mul_step),
        .multiplicand (req_a),
        .multiplier   (req_b),
        .alu_result   (alu_result),
        .hi_next      (hi_next),
        .lo_next      (lo_next),
        .addend_next  (addend_next)
    );

    // ALU inputs are registered one cycle ahead of use: they are loaded with
    // the operands of the cycle that follows the edge, and cleared on the edge
    // that leaves EXEC/MUL so the ALU stays quiet otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_zero  <= 1'b0;
            rsp_lo    <= '0;
            rsp_hi    <= '0;
            alu_ctrl  <= ALU_AND;
            alu_a     <= '0;
            alu_b     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (is_single_op(req_op)) begin
                            state    <= ST_EXEC;
                            alu_ctrl <= req_op;
                            alu_a    <= req_a;
                            alu_b    <= req_b;
                        end else if (req_op == OP_MULT) begin
                            state    <= ST_MUL;
                            cnt      <= '0;
                            alu_ctrl <= ALU_ADD;
                            alu_a    <= hi_next;
                            alu_b    <= addend_next;
                        end else begin
                            // Unsupported code: answer directly, ALU untouched.
                            state     <= ST_DONE;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_zero  <= 1'b1;
                            rsp_lo    <= '0;
                            rsp_hi    <= '0;
                        end
                    end
                end

                ST_EXEC: begin
                    state     <= ST_DONE;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_lo    <= alu_result;
                    rsp_hi    <= '0;
                    rsp_zero  <= (alu_result == '0);
                    alu_ctrl  <= ALU_AND;
                    alu_a     <= '0;
                    alu_b     <= '0;
                end

                ST_MUL: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state     <= ST_DONE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_lo    <= lo_next;
                        rsp_hi    <= hi_next;
                        rsp_zero  <= ({hi_next, lo_next} == '0);
                        alu_ctrl  <= ALU_AND;
                        alu_a     <= '0;
                        alu_b     <= '0;
                    end else begin
                        alu_a <= hi_next;
                        alu_b <= addend_next;
                    end
                end

                ST_DONE: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
// Directed bench for alu_op_sequencer paired with a behavioural MIPSALU.
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge. Latency is counted in rising edges with the accept edge as 1.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;
    import alu_op_sequencer_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_lo;
    logic [WIDTH-1:0] rsp_hi;
    logic             rsp_zero;
    logic             rsp_err;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_lo     (rsp_lo),
        .rsp_hi     (rsp_hi),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .alu_ctrl   (alu_ctrl),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result)
    );

    // Behavioural MIPSALU.
    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            4'b0111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            4'b1100: alu_result = ~(alu_a | alu_b);
            default: alu_result = '0;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Present a request for one edge; returns 1 ns after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Count edges (accept edge = 1) until rsp_valid, bounded.
    task automatic wait_rsp(input string tag, input int exp_lat);
        int n = 1;
        while (!rsp_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 64'(n), 64'(exp_lat));
    endtask

    task automatic check_rsp(input string tag, input logic [31:0] hi, input logic [31:0] lo,
                             input logic zero, input logic err);
        check({tag, "_lo"},   rsp_lo,   lo);
        check({tag, "_hi"},   rsp_hi,   hi);
        check({tag, "_zero"}, rsp_zero, zero);
        check({tag, "_err"},  rsp_err,  err);
    endtask

    // Take the response and confirm the return to idle.
    task automatic consume(input string tag);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check({tag, "_drop_valid"}, rsp_valid, 1'b0);
        check({tag, "_ready"},      req_ready, 1'b1);
    endtask

    initial begin
        #100_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_alu_ctrl",  alu_ctrl,  4'b0000);
        check("rst_alu_a",     alu_a,     32'd0);
        check("rst_alu_b",     alu_b,     32'd0);
        check("rst_rsp",       {rsp_hi, rsp_lo}, 64'd0);
        check("rst_flags",     {rsp_zero, rsp_err}, 2'b00);
        @(negedge clk);
        reset = 1'b0;

        // T1 add 4+6
        issue(4'b0010, 32'd4, 32'd6);
        check("t1_exec_ctrl", alu_ctrl, 4'b0010);
        check("t1_exec_ab",   {alu_a, alu_b}, {32'd4, 32'd6});
        check("t1_busy",      req_ready, 1'b0);
        wait_rsp("t1_lat", 2);
        check_rsp("t1", 32'd0, 32'd10, 1'b0, 1'b0);
        check("t1_alu_quiet", {alu_ctrl, alu_a, alu_b}, 68'd0);

        // T4 backpressure with a pending request that must be ignored
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 4'b0010;
        req_a     = 32'd1;
        req_b     = 32'd1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("t4_valid_hold", rsp_valid, 1'b1);
            check("t4_no_ready",   req_ready, 1'b0);
            check("t4_lo_hold",    rsp_lo,    32'd10);
            check("t4_alu_quiet",  alu_ctrl,  4'b0000);
        end
        @(negedge clk);
        req_valid = 1'b0;
        consume("t4");
        @(posedge clk);
        #1;
        check("t4_no_accept", {rsp_valid, req_ready, alu_ctrl}, 6'b010000);

        // Other single-cycle ops
        issue(4'b0110, 32'd5, 32'd7);
        wait_rsp("sub_lat", 2);
        check_rsp("sub", 32'd0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        consume("sub");
        issue(4'b0110, 32'd6, 32'd6);
        wait_rsp("sub0_lat", 2);
        check_rsp("sub0", 32'd0, 32'd0, 1'b1, 1'b0);
        consume("sub0");
        issue(4'b0111, 32'hFFFF_FFFF, 32'd1);
        wait_rsp("slt_lat", 2);
        check_rsp("slt", 32'd0, 32'd1, 1'b0, 1'b0);
        consume("slt");
        issue(4'b0000, 32'h0000_F0F0, 32'h0000_FF00);
        wait_rsp("and_lat", 2);
        check_rsp("and", 32'd0, 32'h0000_F000, 1'b0, 1'b0);
        consume("and");
        issue(4'b0001, 32'h0000_F0F0, 32'h0000_0F0F);
        wait_rsp("or_lat", 2);
        check_rsp("or", 32'd0, 32'h0000_FFFF, 1'b0, 1'b0);
        consume("or");
        issue(4'b1100, 32'd0, 32'd0);
        wait_rsp("nor_lat", 2);
        check_rsp("nor", 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        consume("nor");

        // T2 MULT all-ones squared: carry chain exercised
        issue(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("t2_mul_ctrl", alu_ctrl, 4'b0010);
        check("t2_mul_ab",   {alu_a, alu_b}, {32'd0, 32'hFFFF_FFFF});
        wait_rsp("t2_lat", 33);
        check_rsp("t2", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
        check("t2_alu_quiet", {alu_ctrl, alu_a, alu_b}, 68'd0);
        consume("t2");

        // T3 MULT by zero, small product, and a product with only the high word set
        issue(4'b1000, 32'd12345, 32'd0);
        wait_rsp("t3a_lat", 33);
        check_rsp("t3a", 32'd0, 32'd0, 1'b1, 1'b0);
        consume("t3a");
        issue(4'b1000, 32'd7, 32'd9);
        check("t3b_mul_ab", {alu_a, alu_b}, {32'd0, 32'd7});
        wait_rsp("t3b_lat", 33);
        check_rsp("t3b", 32'd0, 32'd63, 1'b0, 1'b0);
        consume("t3b");
        issue(4'b1000, 32'h0001_0000, 32'h0001_0000);
        wait_rsp("t3c_lat", 33);
        check_rsp("t3c", 32'd1, 32'd0, 1'b0, 1'b0);
        consume("t3c");

        // T5 reset at iteration 10 of a multiply
        issue(4'b1000, 32'd7, 32'd9);
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t5_rst_valid", rsp_valid, 1'b0);
        check("t5_rst_ctrl",  alu_ctrl,  4'b0000);
        check("t5_rst_idle",  req_ready, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("t5_no_rsp", rsp_valid, 1'b0);
        issue(4'b0010, 32'd4, 32'd6);
        wait_rsp("t5_add_lat", 2);
        check_rsp("t5_add", 32'd0, 32'd10, 1'b0, 1'b0);
        consume("t5_add");

        // T6 illegal op
        issue(4'b0011, 32'd99, 32'd77);
        wait_rsp("t6_lat", 1);
        check_rsp("t6", 32'd0, 32'd0, 1'b1, 1'b1);
        check("t6_alu_quiet", {alu_ctrl, alu_a, alu_b}, 68'd0);
        @(posedge clk);
        #1;
        check("t6_alu_quiet2", alu_ctrl, 4'b0000);
        consume("t6");
        issue(4'b0010, 32'd1, 32'd2);
        wait_rsp("t6_next_lat", 2);
        check_rsp("t6_next", 32'd0, 32'd3, 1'b0, 1'b0);
        consume("t6_next");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
